// File: rtl/loader_pkg.sv
// loader_pkg: shared definitions for the boot-time UART program loader.
//   state_e          - loader FSM state encoding
//   BYTE_CNT_W       - width of the byte-within-word counter
//   DEFAULT_ADDR_W   - default instruction-memory word-address width
//   DEFAULT_MAX_WORDS- default largest accepted image length in words
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam int BYTE_CNT_W        = 2;
  localparam int DEFAULT_ADDR_W    = 10;
  localparam int DEFAULT_MAX_WORDS = 1024;

endpackage

// File: rtl/byte_packer.sv
// byte_packer: assembles four bytes into a little-endian 32-bit word.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (byte counter only)
//   clear      - restart assembly at byte 0
//   strobe     - one received byte on din
//   din[7:0]   - byte to insert
//   word       - registered word; complete in the cycle after word_done
//   word_nxt   - word as it will be after this cycle's byte is inserted
//   word_done  - this strobe carries the 4th byte of the word
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        strobe,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic [31:0] word_nxt,
  output logic        word_done
);

  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]           sr_q, sr_d;

  // Bytes enter at the top and shift down, so the first byte ends in [7:0].
  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (clear) begin
      cnt_d = '0;
    end else if (strobe) begin
      cnt_d = cnt_q + 1'b1;
      sr_d  = {din, sr_q[31:8]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

  assign word      = sr_q;
  assign word_nxt  = sr_d;
  assign word_done = strobe && !clear && (cnt_q == '1);

endmodule

// File: rtl/uart_loader.sv
// uart_loader: boot loader between the UART receiver and instruction memory.
// Receives a 32-bit LE word count then that many LE words and writes them to
// consecutive word addresses from 0, holding the CPU in reset until done.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start               - begin a load (accepted in IDLE, DONE, ERR)
//   rx_data/rx_done     - received byte and its byte-complete level
//   rx_err              - stop-bit error level
//   rx_en               - receiver enable
//   mem_we/addr/wdata   - instruction-memory write port (one-cycle strobe)
//   cpu_hold            - CPU reset hold
//   load_done/load_err  - status levels
//   words_loaded        - words written in the current load
module uart_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int MAX_WORDS = DEFAULT_MAX_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic              rx_err,
  output logic              rx_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  state_e              state_q, state_d;
  logic                rx_done_q, rx_err_q;
  logic                len_chk_q, len_chk_d;
  logic [31:0]         len_q, len_d;
  logic [ADDR_W-1:0]   widx_q, widx_d;
  logic [ADDR_W:0]     wl_q, wl_d;
  logic [31:0]         wdata_q, wdata_d;

  logic                byte_ev, err_ev, start_ok;
  logic                pk_clear, pk_strobe, pk_done;
  logic [31:0]         pk_word, pk_word_nxt;

  assign byte_ev  = rx_done && !rx_done_q;
  assign err_ev   = rx_err && !rx_err_q;
  assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);

  // Bytes are only taken while collecting; during the one-cycle length check
  // the packer holds the completed count word.
  assign pk_clear  = start_ok;
  assign pk_strobe = byte_ev && !err_ev &&
                     ((state_q == ST_LEN && !len_chk_q) || state_q == ST_DATA);

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pk_clear),
    .strobe    (pk_strobe),
    .din       (rx_data),
    .word      (pk_word),
    .word_nxt  (pk_word_nxt),
    .word_done (pk_done)
  );

  always_comb begin
    state_d   = state_q;
    len_chk_d = 1'b0;
    len_d     = len_q;
    widx_d    = widx_q;
    wl_d      = wl_q;
    wdata_d   = wdata_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_ok) begin
          state_d = ST_LEN;
          len_d   = '0;
          widx_d  = '0;
          wl_d    = '0;
        end
      end
      ST_LEN: begin
        if (err_ev) begin
          state_d = ST_ERR;
        end else if (len_chk_q) begin
          len_d = pk_word;
          if (pk_word == 32'd0 || pk_word > 32'(MAX_WORDS)) state_d = ST_ERR;
          else                                              state_d = ST_DATA;
        end else if (pk_done) begin
          len_chk_d = 1'b1;
        end
      end
      ST_DATA: begin
        if (err_ev) begin
          state_d = ST_ERR;
        end else if (pk_done) begin
          wdata_d = pk_word_nxt;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        widx_d = widx_q + 1'b1;
        wl_d   = wl_q + 1'b1;
        if (32'(wl_q) + 32'd1 == len_q) state_d = ST_DONE;
        else                            state_d = ST_DATA;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      len_chk_q <= 1'b0;
      widx_q    <= '0;
      wl_q      <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      len_chk_q <= len_chk_d;
      widx_q    <= widx_d;
      wl_q      <= wl_d;
      wdata_q   <= wdata_d;
    end
  end

  // Edge-detect copies track the inputs even in reset so a level already
  // high when reset releases is not mistaken for a new byte.
  always_ff @(posedge clk) begin
    rx_done_q <= rx_done;
    rx_err_q  <= rx_err;
    len_q     <= len_d;
  end

  assign rx_en        = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_WRITE);
  assign mem_we       = (state_q == ST_WRITE);
  assign mem_addr     = widx_q;
  assign mem_wdata    = wdata_q;
  assign cpu_hold     = (state_q != ST_DONE);
  assign load_done    = (state_q == ST_DONE);
  assign load_err     = (state_q == ST_ERR);
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: randomized scoreboard bench for uart_loader.
module tb_uart_loader;

  localparam int ADDR_W = 10;
  localparam int MAX_W  = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_done = 1'b0;
  logic              rx_err = 1'b0;
  logic              rx_en, mem_we, cpu_hold, load_done, load_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   words_loaded;

  uart_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .rx_err       (rx_err),
    .rx_en        (rx_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    int                cyc;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] img[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: addr %0h data %0h, no write expected (cycle %0d)",
                 mem_addr, mem_wdata, cyc);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(e.addr));
        chk("wr_data", 64'(mem_wdata), 64'(e.data));
        chk("wr_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // One receiver byte: rx_done high for hold cycles (random 1..3 if 0), then
  // at least two low cycles. A write expected from this byte is queued at the
  // moment rx_done rises, due one cycle after that rising cycle.
  task automatic send_byte(input logic [7:0] b, input int hold, input bit allow_start,
                           input bit push, input int addr, input logic [31:0] data);
    int  h;
    wr_t e;
    h = (hold == 0) ? int'($urandom_range(1, 3)) : hold;
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    if (push) begin
      e.addr = addr[ADDR_W-1:0];
      e.data = data;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
    end
    repeat (h - 1) @(negedge clk);
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'($urandom);
    if (allow_start && $urandom_range(0, 2) == 0) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int hold, input bit allow_start,
                           input bit last, input bit push, input int addr);
    for (int i = 0; i < 4; i++) begin
      send_byte(8'((w >> (8 * i)) & 32'hFF), hold, allow_start && !(last && i == 3),
                push && i == 3, addr, w);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rx_en_after_start", 64'(rx_en), 64'd1);
    chk("hold_after_start", 64'(cpu_hold), 64'd1);
  endtask

  task automatic check_status(input bit done, input bit err, input int wl);
    chk("load_done", 64'(load_done), 64'(done));
    chk("load_err", 64'(load_err), 64'(err));
    chk("cpu_hold", 64'(cpu_hold), 64'(!done));
    chk("rx_en_idle", 64'(rx_en), (done || err) ? 64'd0 : 64'd1);
    chk("words_loaded", 64'(words_loaded), 64'(wl));
    chk("mem_we_quiet", 64'(mem_we), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rx_en"}, 64'(rx_en), 64'd0);
    chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
    chk({tag, "_load_done"}, 64'(load_done), 64'd0);
    chk({tag, "_load_err"}, 64'(load_err), 64'd0);
    chk({tag, "_words_loaded"}, 64'(words_loaded), 64'd0);
  endtask

  // Reference model: a count of 1..MAX_W is accepted and its first count
  // words go to addresses 0.. in order; anything else ends in error with no
  // writes. Sends count, then every word in img.
  task automatic run_load(input logic [31:0] count, input int hold);
    bit ok;
    int nsend;
    int exp_wl;
    ok    = (count != 32'd0) && (count <= 32'(MAX_W));
    nsend = img.size();
    do_start();
    send_word(count, hold, 1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < nsend; i++) begin
      send_word(img[i], hold, ok, i == nsend - 1, ok && (32'(i) < count), i);
    end
    repeat (3) @(negedge clk);
    exp_wl = !ok ? 0 : ((32'(nsend) < count) ? nsend : int'(count));
    check_status(ok && (32'(nsend) >= count), !ok, exp_wl);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("idle");

    // Nominal two-word image, rx_done held 3 cycles per byte.
    img = '{32'hDEADBEEF, 32'h12345678};
    run_load(32'd2, 3);
    chk("nominal_addr_after", 64'(mem_addr), 64'd2);

    // Zero length, then bytes that must be discarded in ERR.
    img = '{32'hCAFEF00D};
    run_load(32'd0, 0);

    // Oversize length.
    img = '{32'h0BADF00D};
    run_load(32'h401, 0);

    // Framing error after two data bytes of a one-word image.
    do_start();
    send_word(32'd1, 0, 1'b0, 1'b1, 1'b0, 0);
    send_byte(8'h11, 0, 1'b0, 1'b0, 0, 0);
    send_byte(8'h22, 0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    rx_err = 1'b1;
    @(negedge clk);
    rx_err = 1'b0;
    repeat (3) @(negedge clk);
    check_status(1'b0, 1'b1, 0);
    img = '{32'($urandom)};
    run_load(32'd1, 0);

    // Reset after 5 of 8 data bytes: only the first word is written.
    img = '{32'($urandom), 32'($urandom)};
    do_start();
    send_word(32'd2, 0, 1'b0, 1'b1, 1'b0, 0);
    send_word(img[0], 0, 1'b1, 1'b0, 1'b1, 0);
    send_byte(img[1][7:0], 0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("midload_rst");
    repeat (4) @(negedge clk);
    check_reset_vals("after_rst");
    chk("pending_after_rst", 64'(exp_q.size()), 64'd0);

    // Randomized images, including short and invalid counts.
    for (int t = 0; t < 8; t++) begin
      int          n;
      logic [31:0] count;
      n = int'($urandom_range(1, 6));
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(32'($urandom));
      case ($urandom_range(0, 5))
        0:       count = 32'(MAX_W + 1) + 32'($urandom_range(0, 3));
        1:       count = 32'hFFFF_FFFF;
        default: count = 32'(n);
      endcase
      run_load(count, 0);
    end

    // Largest accepted image.
    img.delete();
    for (int i = 0; i < MAX_W; i++) img.push_back(32'($urandom));
    run_load(32'(MAX_W), 1);

    repeat (4) @(negedge clk);
    chk("writes_outstanding", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
